// File: rtl/l2_prefetch_buffer.sv
// l2_prefetch_buffer
// Next-line prefetch stage between the L2 cache's memory port and physical
// memory. Demand reads and writebacks pass straight through. After every
// demand read or buffer hit, the next 16-byte line is fetched into a
// one-line buffer, so a later L2 miss to that line completes in one cycle.
//
// Optional feature: define L2_PF_STATS_EN to add the pf_issued / pf_hits
// saturating statistics counters and their output ports.
module l2_prefetch_buffer #(
   parameter int unsigned WRAP_PF = 0  // 1: prefetch line 0x000 after line 0xFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  mem_address,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_resp,
   output logic [15:0]  pmem_address,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
`ifdef L2_PF_STATS_EN
   ,
   output logic [15:0]  pf_issued,
   output logic [15:0]  pf_hits
`endif
);

   // FSM encoding
   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_HIT      = 3'd1;
   localparam logic [2:0] S_DEMAND   = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_PREFETCH = 3'd4;

   logic [2:0]   state;
   logic [2:0]   state_next;

   // One-line prefetch buffer and the line currently being prefetched
   logic [127:0] buf_data;
   logic [11:0]  buf_tag;
   logic         buf_valid;
   logic [11:0]  pf_tag;

   // Request decode
   logic [11:0]  req_tag;
   logic         buf_match;
   logic [11:0]  cur_tag;
   logic [11:0]  pf_next_tag;
   logic         pf_allowed;
   logic         pf_start;

   // The byte offset inside a line never matters to this stage.
   logic         unused_offset;
   assign unused_offset = ^mem_address[3:0];

   assign req_tag   = mem_address[15:4];
   assign buf_match = buf_valid && (buf_tag == req_tag);

   // In HIT the line just served is buf_tag; in DEMAND it is the live request.
   assign cur_tag     = (state == S_HIT) ? buf_tag : req_tag;
   assign pf_next_tag = cur_tag + 12'd1;
   // Line 0xFFF's successor wraps to 0x000; only prefetch it when allowed.
   assign pf_allowed  = (cur_tag != 12'hFFF) || (WRAP_PF != 0);

   assign pf_start   = (state != S_PREFETCH) && (state_next == S_PREFETCH);
   assign pmem_wdata = mem_wdata;

   // Next-state selection
   always_comb begin
      // NOTE: defaulting every always_comb output first rules out latches on untaken paths.
      state_next = state;
      case (state)
         S_IDLE: begin
            if (mem_write) begin
               state_next = S_WRITE;
            end else if (mem_read) begin
               state_next = buf_match ? S_HIT : S_DEMAND;
            end
         end
         S_HIT: begin
            state_next = pf_allowed ? S_PREFETCH : S_IDLE;
         end
         S_DEMAND: begin
            if (pmem_resp) begin
               state_next = pf_allowed ? S_PREFETCH : S_IDLE;
            end
         end
         S_WRITE: begin
            if (pmem_resp) begin
               state_next = S_IDLE;
            end
         end
         S_PREFETCH: begin
            if (pmem_resp) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register, buffer tracking and prefetch target capture
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state     <= S_IDLE;
         buf_data  <= '0;
         buf_tag   <= '0;
         buf_valid <= 1'b0;
         pf_tag    <= '0;
      end else begin
         state <= state_next;

         if (state == S_IDLE) begin
            if (mem_write) begin
               // A writeback to the buffered line makes the buffered copy stale.
               if (buf_match) begin
                  buf_valid <= 1'b0;
               end
            end else if (mem_read) begin
               // A hit consumes the line; a miss discards it in favour of
               // the prefetch that follows the demand read.
               buf_valid <= 1'b0;
            end
         end

         if (pf_start) begin
            pf_tag <= pf_next_tag;
         end

         if ((state == S_PREFETCH) && pmem_resp) begin
            buf_data  <= pmem_rdata;
            buf_tag   <= pf_tag;
            buf_valid <= 1'b1;
         end
      end
   end

   // Drive the L2-side response and the memory-side request from the state
   always_comb begin
      mem_rdata    = '0;
      mem_resp     = 1'b0;
      pmem_address = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      case (state)
         S_HIT: begin
            mem_rdata = buf_data;
            mem_resp  = 1'b1;
         end
         S_DEMAND: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, 4'h0};
            mem_rdata    = pmem_rdata;
            mem_resp     = pmem_resp;
         end
         S_WRITE: begin
            pmem_write   = 1'b1;
            pmem_address = {req_tag, 4'h0};
            mem_resp     = pmem_resp;
         end
         S_PREFETCH: begin
            // Prefetches are invisible to the L2: no response is given.
            pmem_read    = 1'b1;
            pmem_address = {pf_tag, 4'h0};
         end
         default: begin
         end
      endcase
   end

`ifdef L2_PF_STATS_EN
   logic hit_start;
   assign hit_start = (state == S_IDLE) && (state_next == S_HIT);

   // Saturating counters of prefetches started and buffer hits
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_issued <= '0;
         pf_hits   <= '0;
      end else begin
         if (pf_start && (pf_issued != 16'hFFFF)) begin
            pf_issued <= pf_issued + 16'd1;
         end
         if (hit_start && (pf_hits != 16'hFFFF)) begin
            pf_hits <= pf_hits + 16'd1;
         end
      end
   end
`else
   // Statistics disabled: no counters or ports are built.
`endif

endmodule

// File: tb/tb_l2_prefetch_buffer.sv
// tb_l2_prefetch_buffer
// Two instances share the same upstream stimulus: g_dut[0] has WRAP_PF = 0,
// g_dut[1] has WRAP_PF = 1. Each has its own memory model with a programmable
// latency. Read responses of instance 0 are checked against a scoreboard.
// Define L2_PF_STATS_EN to also check the statistics counters.
module tb_l2_prefetch_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [127:0] mem_wdata;
   logic         inj_resp;
   int           mem_lat;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit           wr;
      logic [127:0] data;
   } sb_t;

   sb_t         sb[$];
   logic [15:0] rd_log[$];  // memory reads completed by instance 0, in order

   always #5 clk = ~clk;

   // Distinct, recognisable contents for every memory line
   function automatic logic [127:0] line_data(input logic [11:0] t);
      return {4{t, 20'h5A5A5 ^ {8'h00, t}}};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   for (genvar i = 0; i < 2; i++) begin : g_dut
      logic [127:0] rdata;
      logic         resp;
      logic [15:0]  paddr;
      logic         pread;
      logic         pwrite;
      logic [127:0] pwdata;
      logic [127:0] prdata = '0;
      logic         mresp  = 1'b0;
      logic         presp;
      int           cnt    = 0;
`ifdef L2_PF_STATS_EN
      logic [15:0]  issued;
      logic [15:0]  hits;
`endif

      assign presp = mresp | inj_resp;

      l2_prefetch_buffer #(.WRAP_PF(i)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .mem_address  (mem_address),
         .mem_read     (mem_read),
         .mem_write    (mem_write),
         .mem_wdata    (mem_wdata),
         .mem_rdata    (rdata),
         .mem_resp     (resp),
         .pmem_address (paddr),
         .pmem_read    (pread),
         .pmem_write   (pwrite),
         .pmem_wdata   (pwdata),
         .pmem_rdata   (prdata),
         .pmem_resp    (presp)
`ifdef L2_PF_STATS_EN
         ,
         .pf_issued    (issued),
         .pf_hits      (hits)
`endif
      );

      // Memory model: responds mem_lat cycles after a request is first seen
      always @(posedge clk) begin
         mresp <= 1'b0;
         if (mresp) begin
            cnt <= 0;
         end else if (pread || pwrite) begin
            if (cnt >= mem_lat - 1) begin
               mresp  <= 1'b1;
               prdata <= line_data(paddr[15:4]);
               cnt    <= 0;
               if (i == 0 && pread) rd_log.push_back(paddr);
            end else begin
               cnt <= cnt + 1;
            end
         end else begin
            cnt <= 0;
         end
      end
   end

   // Scoreboard pop on every response of instance 0, plus read/write exclusion
   always @(negedge clk) begin
      sb_t e;
      if (g_dut[0].resp) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 128'(g_dut[0].resp), 128'd0);
         end else begin
            e = sb.pop_front();
            if (!e.wr) check("rdata", g_dut[0].rdata, e.data);
         end
      end
      if (g_dut[0].pread || g_dut[0].pwrite)
         check("rw_exclusive", 128'(g_dut[0].pread & g_dut[0].pwrite), 128'd0);
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait for instance 0's response; a missing response counts as a failure.
   task automatic wait_resp(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!g_dut[0].resp && cycles < 300);
      check("resp_seen", 128'(g_dut[0].resp), 128'd1);
   endtask

   // Issue a read at a negedge and return the cycles until mem_resp
   task automatic do_read(input logic [15:0] addr, output int cycles);
      sb.push_back('{wr: 1'b0, data: line_data(addr[15:4])});
      mem_address = addr;
      mem_read    = 1'b1;
      wait_resp(cycles);
      mem_read    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int n;
      rst         = 1'b1;
      mem_address = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wdata   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      inj_resp    = 1'b0;
      mem_lat     = 5;

      // Reset state
      settle(3);
      check("rst_mem_resp",  128'(g_dut[0].resp),  128'd0);
      check("rst_mem_rdata", g_dut[0].rdata,        128'd0);
      check("rst_pmem_read", 128'(g_dut[0].pread),  128'd0);
      check("rst_pmem_wr",   128'(g_dut[0].pwrite), 128'd0);
      check("rst_pmem_addr", 128'(g_dut[0].paddr),  128'd0);
      check("rst_buf_valid", 128'(g_dut[0].u_dut.buf_valid), 128'd0);
      check("rst_wdata",     g_dut[0].pwdata, mem_wdata);
      rst = 1'b0;
      settle(1);

      // Demand read 0x1230: one cycle to leave IDLE plus 5 cycles of memory
      do_read(16'h1230, cyc);
      check("demand_latency", 128'(cyc), 128'd6);
      check("demand_addr",    128'(rd_log[0]), 128'h1230);
      settle(1);
      check("pf_1240_read", 128'(g_dut[0].pread), 128'd1);
      check("pf_1240_addr", 128'(g_dut[0].paddr), 128'h1240);
      check("pf_no_resp",   128'(g_dut[0].resp),  128'd0);
      settle(8);
      check("pf_1240_valid", 128'(g_dut[0].u_dut.buf_valid), 128'd1);
      check("pf_1240_log",   128'(rd_log[rd_log.size()-1]), 128'h1240);

      // Read 0x1244 hits the buffered 0x1240 line in one cycle
      n = rd_log.size();
      do_read(16'h1244, cyc);
      check("hit_latency",   128'(cyc), 128'd1);
      check("hit_no_pmem",   128'(rd_log.size()), 128'(n));
      check("hit_buf_clear", 128'(g_dut[0].u_dut.buf_valid), 128'd0);
      settle(1);
      check("pf_1250_read", 128'(g_dut[0].pread), 128'd1);
      check("pf_1250_addr", 128'(g_dut[0].paddr), 128'h1250);
      settle(8);

      // Reload buffer with 0x1240, then write 0x1240 to invalidate it
      do_read(16'h1230, cyc);
      check("demand2_latency", 128'(cyc), 128'd6);
      settle(9);
      check("buf_tag_1240", 128'(g_dut[0].u_dut.buf_tag), 128'h124);
      sb.push_back('{wr: 1'b1, data: '0});
      mem_address = 16'h1240;
      mem_wdata   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      mem_write   = 1'b1;
      settle(1);
      check("wr_pmem_write", 128'(g_dut[0].pwrite), 128'd1);
      check("wr_pmem_read",  128'(g_dut[0].pread),  128'd0);
      check("wr_pmem_addr",  128'(g_dut[0].paddr),  128'h1240);
      check("wr_pmem_wdata", g_dut[0].pwdata, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
      check("wr_buf_clear",  128'(g_dut[0].u_dut.buf_valid), 128'd0);
      wait_resp(cyc);
      mem_write = 1'b0;
      check("write_latency", 128'(cyc + 1), 128'd6);
      settle(1);
      do_read(16'h1240, cyc);
      check("after_wr_demand",  128'(cyc), 128'd6);
      check("after_wr_pmem",    128'(rd_log[rd_log.size()-1]), 128'h1240);
      settle(9);

      // Read 0x5000 while its prefetch is in flight: stalls, then HIT
      do_read(16'h4FF0, cyc);
      settle(1);
      check("pf_5000_addr", 128'(g_dut[0].paddr), 128'h5000);
      n = rd_log.size();
      do_read(16'h5000, cyc);
      check("stall_latency", 128'(cyc), 128'd7);
      check("stall_one_read", 128'(rd_log.size()), 128'(n + 1));
      check("stall_pf_addr",  128'(rd_log[rd_log.size()-1]), 128'h5000);
      settle(9);

`ifdef L2_PF_STATS_EN
      check("stats_issued", 128'(g_dut[0].issued), 128'd6);
      check("stats_hits",   128'(g_dut[0].hits),   128'd2);
`endif

      // Line 0xFFF: instance 0 suppresses the wrap, instance 1 prefetches 0x000
      n = rd_log.size();
      do_read(16'hFFF0, cyc);
      check("wrap_demand", 128'(rd_log[rd_log.size()-1]), 128'hFFF0);
      settle(1);
      check("nowrap_idle",     128'(g_dut[0].pread), 128'd0);
      check("nowrap_state",    128'(g_dut[0].u_dut.state), 128'd0);
      check("wrap_pf_read",    128'(g_dut[1].pread), 128'd1);
      check("wrap_pf_addr",    128'(g_dut[1].paddr), 128'h0000);
      settle(8);
      check("nowrap_no_pf",    128'(rd_log.size()), 128'(n + 1));
      check("nowrap_buf",      128'(g_dut[0].u_dut.buf_valid), 128'd0);
      check("wrap_buf_valid",  128'(g_dut[1].u_dut.buf_valid), 128'd1);
      check("wrap_buf_tag",    128'(g_dut[1].u_dut.buf_tag), 128'h000);

      // Reset during DEMAND; a late pmem_resp must be ignored
      mem_lat     = 1000;
      mem_address = 16'h2000;
      mem_read    = 1'b1;
      settle(3);
      check("rst_mid_read", 128'(g_dut[0].pread), 128'd1);
      check("rst_mid_addr", 128'(g_dut[0].paddr), 128'h2000);
      rst      = 1'b1;
      mem_read = 1'b0;
      settle(1);
      check("rst_drop_read", 128'(g_dut[0].pread), 128'd0);
      rst = 1'b0;
      settle(1);
      inj_resp = 1'b1;
      settle(1);
      check("late_resp_ignored", 128'(g_dut[0].resp), 128'd0);
      inj_resp = 1'b0;
      settle(1);
      check("late_state_idle", 128'(g_dut[0].u_dut.state), 128'd0);
      check("late_no_read",    128'(g_dut[0].pread), 128'd0);
      check("late_buf_valid",  128'(g_dut[0].u_dut.buf_valid), 128'd0);
`ifdef L2_PF_STATS_EN
      check("rst_stats_issued", 128'(g_dut[0].issued), 128'd0);
      check("rst_stats_hits",   128'(g_dut[0].hits),   128'd0);
`endif
      settle(2);
      check("sb_drained", 128'(sb.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/l2_prefetch_buffer.md
# l2_prefetch_buffer

Next-line prefetch stage between the L2 (eightway) cache's physical-memory port and physical memory / the eviction write buffer. Passes L2 demand reads and writebacks through to memory. After every demand read it fetches the sequentially next 16-byte line into a one-line buffer, so a later L2 miss to that line completes in one cycle without a memory access.

## Interface
- `WRAP_PF`, default 0: 1 allows prefetching line 0x000 after line 0xFFF; 0 suppresses that prefetch.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_address`  in  16  L2-side byte address; bits [15:4] select the line.
- `mem_read`  in  1  L2 line-read request; held until `mem_resp`.
- `mem_write`  in  1  L2 line-write (eviction) request; held until `mem_resp`.
- `mem_wdata`  in  128  write line (`cache_line`).
- `mem_rdata`  out  128  read line returned to L2.
- `mem_resp`  out  1  one-cycle completion pulse to L2.
- `pmem_address`  out  16  memory line address, bits [3:0] always 0.
- `pmem_read`  out  1  memory read request.
- `pmem_write`  out  1  memory write request.
- `pmem_wdata`  out  128  equals `mem_wdata`.
- `pmem_rdata`  in  128  memory read data, valid with `pmem_resp`.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- State: FSM {IDLE, HIT, DEMAND, WRITE, PREFETCH}; buffer line `buf_data`; tag `buf_tag` [11:0]; `buf_valid`; prefetch target `pf_tag` [11:0].
- IDLE, `mem_write`: go to WRITE. If `buf_valid` and `buf_tag == mem_address[15:4]`, clear `buf_valid` on the same edge. Write has priority over read; both asserted together is illegal.
- IDLE, `mem_read` with `buf_valid` and a tag match: go to HIT and clear `buf_valid`.
- IDLE, `mem_read` with no match: go to DEMAND.
- HIT: `mem_rdata = buf_data`, `mem_resp = 1` for exactly one cycle. Then go to PREFETCH with `pf_tag = hit tag + 1`, or to IDLE if that increment wraps and `WRAP_PF = 0`.
- DEMAND: `pmem_read = 1`, `pmem_address = {mem_address[15:4],4'h0}`. `mem_rdata = pmem_rdata` and `mem_resp = pmem_resp`, combinational pass-through. On `pmem_resp`, go to PREFETCH with `pf_tag = tag + 1` (same wrap rule). Any previous buffer contents are discarded.
- WRITE: `pmem_write = 1`, address as above, `mem_resp = pmem_resp`. On `pmem_resp`, go to IDLE.
- PREFETCH: `pmem_read = 1`, `pmem_address = {pf_tag,4'h0}`, `mem_resp = 0`. On `pmem_resp`, load `buf_data = pmem_rdata` and `buf_tag = pf_tag`, set `buf_valid`, and go to IDLE.
- Upstream requests arriving during PREFETCH stall; the prefetch is never aborted. They are serviced from IDLE, so a read of `pf_tag` becomes a HIT.
- `pmem_resp` seen in IDLE or HIT is ignored.

## Timing
- Reset values: state IDLE, `buf_valid` 0, `buf_tag`/`pf_tag`/`buf_data` 0. All outputs 0; `pmem_wdata` follows `mem_wdata`.
- Reset mid-operation: the next state is IDLE and `pmem_read`/`pmem_write` drop the cycle after the reset edge. A late `pmem_resp` is ignored.
- Hit latency: request sampled in IDLE at edge N; `mem_resp` is high during cycle N+1.
- Miss and write latency: one cycle to leave IDLE, then memory latency. `mem_resp` is high in the same cycle as `pmem_resp`.
- `pmem_read` and `pmem_write` are never high together; the address is stable while either is high.
- Worst case for a request arriving during PREFETCH: the remaining prefetch time, plus one cycle, plus its own service time.

## Configuration
- `L2_PF_STATS_EN` defined: adds outputs `pf_issued` (16, count of prefetches started) and `pf_hits` (16, count of HIT entries). Both saturate at 0xFFFF and are cleared by `rst`.
- `L2_PF_STATS_EN` undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Read 0x1230, memory latency 5 → `pmem_read` to 0x1230, then `mem_resp` with its data; prefetch of 0x1240 follows automatically, `buf_valid` = 1.
- After that, read 0x1244 → `mem_resp` one cycle after the request with the 0x1240 line, no `pmem_read` for it; then prefetch of 0x1250.
- Buffer holds 0x1240, write 0x1240 → `pmem_write` to 0x1240, `buf_valid` cleared; a subsequent read 0x1240 goes to memory (DEMAND).
- Read 0x5000 issued while prefetch of 0x5000 is in flight → `mem_resp` held low until the prefetch completes, then HIT with no second memory read.
- Read 0xFFF0 with `WRAP_PF` = 0 → no prefetch, return to IDLE; with `WRAP_PF` = 1 → prefetch of 0x0000.
- Assert `rst` during DEMAND, then a `pmem_resp` 2 cycles later → no `mem_resp`, state IDLE. With `L2_PF_STATS_EN`, both counters read 0.
